// File: rtl/vscale_wb_arbiter.sv
// rtl/vscale_wb_arbiter.sv - writeback arbiter: pipe/mul-div merge, pending scoreboard, bypass hits
// Optional feature macro: WB_BYPASS_EN (forward wd to decode; otherwise decode stalls on it)
module vscale_wb_arbiter #(
  parameter int XPR_LEN        = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      pipe_wen,
  input  logic [REG_ADDR_WIDTH-1:0] pipe_wa,
  input  logic [XPR_LEN-1:0]        pipe_wd,
  input  logic                      issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0] issue_wa,
  input  logic                      md_valid,
  output logic                      md_ready,
  input  logic [REG_ADDR_WIDTH-1:0] md_wa,
  input  logic [XPR_LEN-1:0]        md_wd,
  output logic                      wen,
  output logic [REG_ADDR_WIDTH-1:0] wa,
  output logic [XPR_LEN-1:0]        wd,
  input  logic [REG_ADDR_WIDTH-1:0] ra1,
  input  logic [REG_ADDR_WIDTH-1:0] ra2,
  output logic                      busy1,
  output logic                      busy2,
  output logic                      byp1_hit,
  output logic                      byp2_hit
);

  localparam int NREGS = 1 << REG_ADDR_WIDTH;

  logic [REG_ADDR_WIDTH-1:0] fifo_wa [2];
  logic [XPR_LEN-1:0]        fifo_wd [2];
  logic                      wr_ptr;
  logic                      rd_ptr;
  logic [1:0]                count;
  logic [NREGS-1:0]          pending;
  logic [NREGS-1:0]          set_mask;
  logic [NREGS-1:0]          clr_mask;
  logic                      pipe_write;
  logic                      md_push;
  logic                      fifo_pop;
  logic                      hazard1;
  logic                      hazard2;

  // Ready depends on registered count only, so a full FIFO never passes through
  assign md_ready   = ~count[1];
  // Writes to x0 are not real writes: they neither claim the port nor enter the FIFO
  assign pipe_write = pipe_wen && (pipe_wa != '0);
  assign md_push    = md_valid && md_ready && (md_wa != '0);
  assign fifo_pop   = !pipe_write && (count != 2'd0);

  // Scoreboard update masks; applying set after clear makes a same-edge set win
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && (issue_wa != '0)) set_mask[issue_wa] = 1'b1;
    if (fifo_pop) clr_mask[fifo_wa[rd_ptr]] = 1'b1;
  end

  // Output register: pipeline has priority, FIFO head drains in idle pipe cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wen <= 1'b0;
      wa  <= '0;
      wd  <= '0;
    end else if (pipe_write) begin
      wen <= 1'b1;
      wa  <= pipe_wa;
      wd  <= pipe_wd;
    end else if (fifo_pop) begin
      wen <= 1'b1;
      wa  <= fifo_wa[rd_ptr];
      wd  <= fifo_wd[rd_ptr];
    end else begin
      wen <= 1'b0;
    end
  end

  // FIFO storage; contents are meaningless while count says the slot is empty
  always_ff @(posedge clk) begin
    if (md_push) begin
      fifo_wa[wr_ptr] <= md_wa;
      fifo_wd[wr_ptr] <= md_wd;
    end
  end

  // FIFO pointers, occupancy and pending-write scoreboard
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      pending <= '0;
    end else begin
      wr_ptr  <= wr_ptr ^ md_push;
      rd_ptr  <= rd_ptr ^ fifo_pop;
      count   <= count + {1'b0, md_push} - {1'b0, fifo_pop};
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

  assign hazard1 = wen && (wa == ra1) && (ra1 != '0);
  assign hazard2 = wen && (wa == ra2) && (ra2 != '0);

`ifdef WB_BYPASS_EN
  assign byp1_hit = hazard1;
  assign byp2_hit = hazard2;
  assign busy1    = pending[ra1] && (ra1 != '0);
  assign busy2    = pending[ra2] && (ra2 != '0);
`else
  assign byp1_hit = 1'b0;
  assign byp2_hit = 1'b0;
  assign busy1    = (pending[ra1] && (ra1 != '0)) || hazard1;
  assign busy2    = (pending[ra2] && (ra2 != '0)) || hazard2;
`endif

endmodule

// File: tb/tb_vscale_wb_arbiter.sv
// tb/tb_vscale_wb_arbiter.sv - self-checking bench for vscale_wb_arbiter
module tb_vscale_wb_arbiter;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pipe_wen;
  logic [4:0]  pipe_wa;
  logic [31:0] pipe_wd;
  logic        issue_valid;
  logic [4:0]  issue_wa;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_wa;
  logic [31:0] md_wd;
  logic        wen;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        busy1;
  logic        busy2;
  logic        byp1_hit;
  logic        byp2_hit;

  int tests = 0;
  int fails = 0;

  vscale_wb_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .pipe_wen(pipe_wen), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
    .issue_valid(issue_valid), .issue_wa(issue_wa),
    .md_valid(md_valid), .md_ready(md_ready), .md_wa(md_wa), .md_wd(md_wd),
    .wen(wen), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .busy1(busy1), .busy2(busy2),
    .byp1_hit(byp1_hit), .byp2_hit(byp2_hit)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk5(input string nm, input logic [4:0] act, input logic [4:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    pipe_wen = 1'b0; pipe_wa = 5'd0; pipe_wd = 32'd0;
    issue_valid = 1'b0; issue_wa = 5'd0;
    md_valid = 1'b0; md_wa = 5'd0; md_wd = 32'd0;
  endtask

  // Directed vectors: inputs for one cycle, pre-edge expectations, post-edge outputs
  typedef struct packed {
    logic        pw;  logic [4:0] pa;  logic [31:0] pd;
    logic        iv;  logic [4:0] ia;
    logic        mv;  logic [4:0] mwa; logic [31:0] mwd;
    logic [4:0]  ra;
    logic        rdy; logic       pend; logic       hit;
    logic        wen; logic [4:0] wa;  logic [31:0] wd;
  } vec_t;

  // Reference model: queue of waiting results, pending set, output register
  typedef struct packed { logic [4:0] wa; logic [31:0] wd; } ent_t;
  ent_t        mq[$];
  bit          mpend[32];
  logic        m_wen;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 32; i++) mpend[i] = 1'b0;
    m_wen = 1'b0; m_wa = 5'd0; m_wd = 32'd0;
  endtask

  task automatic model_step();
    bit   room;
    ent_t h;
    room = (mq.size() < 2);
    if (pipe_wen && pipe_wa != 5'd0) begin
      m_wen = 1'b1; m_wa = pipe_wa; m_wd = pipe_wd;
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      m_wen = 1'b1; m_wa = h.wa; m_wd = h.wd;
      mpend[h.wa] = 1'b0;
    end else begin
      m_wen = 1'b0;
    end
    if (md_valid && room && md_wa != 5'd0) mq.push_back('{wa: md_wa, wd: md_wd});
    if (issue_valid && issue_wa != 5'd0) mpend[issue_wa] = 1'b1;
  endtask

  function automatic bit m_hit(input logic [4:0] r);
    return m_wen && (m_wa == r) && (r != 5'd0);
  endfunction

  function automatic bit m_busy(input logic [4:0] r);
    return (mpend[r] && r != 5'd0) || (!BYP && m_hit(r));
  endfunction

  vec_t vec [15];
  int   writes;
  logic [4:0]  last_wa;
  logic [31:0] last_wd;

  initial begin
    vec[0]  = '{1'b1,5'd5,32'h1234, 1'b0,5'd0, 1'b0,5'd0,32'h0,   5'd5,  1'b1,1'b0,1'b0, 1'b1,5'd5,32'h1234};
    vec[1]  = '{1'b0,5'd0,32'h0,    1'b1,5'd7, 1'b0,5'd0,32'h0,   5'd5,  1'b1,1'b0,1'b1, 1'b0,5'd5,32'h1234};
    vec[2]  = '{1'b1,5'd1,32'h11,   1'b0,5'd0, 1'b1,5'd7,32'hAA,  5'd7,  1'b1,1'b1,1'b0, 1'b1,5'd1,32'h11};
    vec[3]  = '{1'b1,5'd2,32'h22,   1'b0,5'd0, 1'b0,5'd0,32'h0,   5'd7,  1'b1,1'b1,1'b0, 1'b1,5'd2,32'h22};
    vec[4]  = '{1'b1,5'd3,32'h33,   1'b0,5'd0, 1'b0,5'd0,32'h0,   5'd7,  1'b1,1'b1,1'b0, 1'b1,5'd3,32'h33};
    vec[5]  = '{1'b0,5'd0,32'h0,    1'b0,5'd0, 1'b0,5'd0,32'h0,   5'd7,  1'b1,1'b1,1'b0, 1'b1,5'd7,32'hAA};
    vec[6]  = '{1'b0,5'd0,32'h0,    1'b0,5'd0, 1'b0,5'd0,32'h0,   5'd7,  1'b1,1'b0,1'b1, 1'b0,5'd7,32'hAA};
    vec[7]  = '{1'b1,5'd4,32'h44,   1'b1,5'd8, 1'b1,5'd8,32'h1,   5'd8,  1'b1,1'b0,1'b0, 1'b1,5'd4,32'h44};
    vec[8]  = '{1'b1,5'd4,32'h45,   1'b1,5'd9, 1'b1,5'd9,32'h2,   5'd8,  1'b1,1'b1,1'b0, 1'b1,5'd4,32'h45};
    vec[9]  = '{1'b1,5'd4,32'h46,   1'b0,5'd0, 1'b1,5'd10,32'h3,  5'd9,  1'b0,1'b1,1'b0, 1'b1,5'd4,32'h46};
    vec[10] = '{1'b0,5'd0,32'h0,    1'b0,5'd0, 1'b1,5'd10,32'h3,  5'd8,  1'b0,1'b1,1'b0, 1'b1,5'd8,32'h1};
    vec[11] = '{1'b0,5'd0,32'h0,    1'b0,5'd0, 1'b1,5'd10,32'h3,  5'd8,  1'b1,1'b0,1'b1, 1'b1,5'd9,32'h2};
    vec[12] = '{1'b1,5'd0,32'hFFFF, 1'b0,5'd0, 1'b0,5'd0,32'h0,   5'd9,  1'b1,1'b0,1'b1, 1'b1,5'd10,32'h3};
    vec[13] = '{1'b0,5'd0,32'h0,    1'b0,5'd0, 1'b1,5'd0,32'h55,  5'd10, 1'b1,1'b0,1'b1, 1'b0,5'd10,32'h3};
    vec[14] = '{1'b0,5'd0,32'h0,    1'b1,5'd0, 1'b0,5'd0,32'h0,   5'd0,  1'b1,1'b0,1'b0, 1'b0,5'd10,32'h3};

    // Reset state
    reset_n = 1'b0;
    idle_inputs();
    ra1 = 5'd0; ra2 = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk1("reset_wen", wen, 1'b0);
    chk5("reset_wa", wa, 5'd0);
    chk32("reset_wd", wd, 32'd0);
    chk1("reset_md_ready", md_ready, 1'b1);
    reset_n = 1'b1;

    // Directed table
    for (int i = 0; i < 15; i++) begin
      pipe_wen = vec[i].pw; pipe_wa = vec[i].pa; pipe_wd = vec[i].pd;
      issue_valid = vec[i].iv; issue_wa = vec[i].ia;
      md_valid = vec[i].mv; md_wa = vec[i].mwa; md_wd = vec[i].mwd;
      ra1 = vec[i].ra; ra2 = vec[i].ra;
      #1;
      chk1($sformatf("tbl%0d_md_ready", i), md_ready, vec[i].rdy);
      chk1($sformatf("tbl%0d_busy1", i), busy1, vec[i].pend | (!BYP & vec[i].hit));
      chk1($sformatf("tbl%0d_busy2", i), busy2, vec[i].pend | (!BYP & vec[i].hit));
      chk1($sformatf("tbl%0d_byp1", i), byp1_hit, BYP & vec[i].hit);
      chk1($sformatf("tbl%0d_byp2", i), byp2_hit, BYP & vec[i].hit);
      @(posedge clk);
      #1;
      chk1($sformatf("tbl%0d_wen", i), wen, vec[i].wen);
      chk5($sformatf("tbl%0d_wa", i), wa, vec[i].wa);
      chk32($sformatf("tbl%0d_wd", i), wd, vec[i].wd);
    end

    // Mid-cycle reset with a full FIFO and pending x8/x9
    idle_inputs();
    pipe_wen = 1'b1; pipe_wa = 5'd1; pipe_wd = 32'h1;
    issue_valid = 1'b1; issue_wa = 5'd8;
    md_valid = 1'b1; md_wa = 5'd8; md_wd = 32'h1;
    @(posedge clk); #1;
    pipe_wa = 5'd2; pipe_wd = 32'h2;
    issue_wa = 5'd9;
    md_wa = 5'd9; md_wd = 32'h2;
    @(posedge clk); #1;
    idle_inputs();
    ra1 = 5'd8; ra2 = 5'd9;
    #1;
    chk1("prerst_md_ready", md_ready, 1'b0);
    chk1("prerst_busy1", busy1, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    chk1("midrst_wen", wen, 1'b0);
    chk5("midrst_wa", wa, 5'd0);
    chk32("midrst_wd", wd, 32'd0);
    chk1("midrst_md_ready", md_ready, 1'b1);
    chk1("midrst_busy1", busy1, 1'b0);
    chk1("midrst_busy2", busy2, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    md_valid = 1'b1; md_wa = 5'd12; md_wd = 32'h77;
    @(posedge clk); #1;
    idle_inputs();
    writes = 0; last_wa = 5'd0; last_wd = 32'd0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (wen) begin
        writes++; last_wa = wa; last_wd = wd;
      end
    end
    chk32("postrst_write_count", writes, 32'd1);
    chk5("postrst_wa", last_wa, 5'd12);
    chk32("postrst_wd", last_wd, 32'h77);

    // Randomized run against the reference model
    reset_n = 1'b0;
    idle_inputs();
    #2;
    reset_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    for (int c = 0; c < 1500; c++) begin
      pipe_wen = ($urandom_range(0, 1) == 1);
      pipe_wa = 5'($urandom_range(0, 7));
      pipe_wd = $urandom;
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_wa = 5'($urandom_range(0, 7));
      md_valid = ($urandom_range(0, 2) != 0);
      md_wa = 5'($urandom_range(0, 7));
      md_wd = $urandom;
      ra1 = 5'($urandom_range(0, 7));
      ra2 = 5'($urandom_range(0, 7));
      #1;
      chk1("rnd_md_ready", md_ready, mq.size() < 2);
      chk1("rnd_busy1", busy1, m_busy(ra1));
      chk1("rnd_busy2", busy2, m_busy(ra2));
      chk1("rnd_byp1", byp1_hit, BYP && m_hit(ra1));
      chk1("rnd_byp2", byp2_hit, BYP && m_hit(ra2));
      @(posedge clk);
      model_step();
      #1;
      chk1("rnd_wen", wen, m_wen);
      chk5("rnd_wa", wa, m_wa);
      chk32("rnd_wd", wd, m_wd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
